// File: rtl/prog_load_ctrl_if.sv
// Purpose: bundles the host byte link, instruction-memory write port, core
// debug/reset pins and run status of the program-load sequencer.
//   master modport : the sequencer (drives rxReady, insMem*, cpuReset, status)
//   slave modport  : the environment (host link + core)
interface prog_load_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [7:0]       rxData;
  logic             rxValid;
  logic             rxReady;
  logic             insMemEn;
  logic [WIDTH-1:0] insMemAddr;
  logic [WIDTH-1:0] insMemData;
  logic             cpuReset;
  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] a7;
  logic [WIDTH-1:0] a0;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic             loadErr;
  logic [31:0]      cycleCount;

  modport master (
    input  start, rxData, rxValid, gp, a7, a0,
    output rxReady, insMemEn, insMemAddr, insMemData, cpuReset,
           busy, done, pass, timeout, loadErr, cycleCount
  );

  modport slave (
    output start, rxData, rxValid, gp, a7, a0,
    input  rxReady, insMemEn, insMemAddr, insMemData, cpuReset,
           busy, done, pass, timeout, loadErr, cycleCount
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Purpose: receives a program as a little-endian byte stream (16-bit word
// count header, then words), writes it into the core's instruction memory,
// releases the core and watches for the a7 exit convention or a cycle budget.
// Ports:
//   clock, reset : single clock, asynchronous active-high reset
//   bus          : prog_load_ctrl_if.master (host link, imem write, core
//                  reset/debug registers, busy/done/pass/timeout/loadErr,
//                  cycleCount)
module prog_load_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned EXIT_CODE  = 93
) (
  input  logic               clock,
  input  logic               reset,
  prog_load_ctrl_if.master   bus
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ASM_W = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_RUN, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic               rx_ready_q, rx_ready_d;
  logic               ins_mem_en_q, ins_mem_en_d;
  logic [WIDTH-1:0]   ins_mem_addr_q, ins_mem_addr_d;
  logic [WIDTH-1:0]   ins_mem_data_q, ins_mem_data_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [WIDTH-1:0]   a7_prev_q, a7_prev_d;

  logic               rx_hs_c;
  logic [IDX_W-1:0]   hdr_n_c;
  logic               exit_hit_c;
  logic               last_byte_c;

  assign rx_hs_c    = bus.rxValid & rx_ready_q;
  assign hdr_n_c    = {bus.rxData, n_q[7:0]};
  // Exit is an edge on a7: a value already at EXIT_CODE never triggers.
  assign exit_hit_c = (bus.a7 == WIDTH'(EXIT_CODE)) && (a7_prev_q != WIDTH'(EXIT_CODE));
  // Final byte of the final word: stop accepting bytes right away.
  assign last_byte_c = (state_q == S_LOAD) && rx_hs_c && (byte_cnt_q == 2'd3) &&
                       (idx_q == n_q - IDX_W'(1));

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      idx_q          <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      rx_ready_q     <= 1'b0;
      ins_mem_en_q   <= 1'b0;
      ins_mem_addr_q <= '0;
      ins_mem_data_q <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      load_err_q     <= 1'b0;
      cycle_count_q  <= '0;
      a7_prev_q      <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      rx_ready_q     <= rx_ready_d;
      ins_mem_en_q   <= ins_mem_en_d;
      ins_mem_addr_q <= ins_mem_addr_d;
      ins_mem_data_q <= ins_mem_data_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      load_err_q     <= load_err_d;
      cycle_count_q  <= cycle_count_d;
      a7_prev_q      <= a7_prev_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    idx_d          = idx_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    ins_mem_en_d   = 1'b0;
    ins_mem_addr_d = ins_mem_addr_q;
    ins_mem_data_d = ins_mem_data_q;
    done_d         = done_q;
    pass_d         = pass_q;
    timeout_d      = timeout_q;
    load_err_d     = load_err_q;
    cycle_count_d  = cycle_count_q;
    a7_prev_d      = bus.a7;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d       = S_HDR0;
          n_d           = '0;
          idx_d         = '0;
          byte_cnt_d    = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          load_err_d    = 1'b0;
          cycle_count_d = '0;
        end
      end
      S_HDR0: begin
        if (rx_hs_c) begin
          n_d     = {8'd0, bus.rxData};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (rx_hs_c) begin
          n_d = hdr_n_c;
          if ((hdr_n_c == '0) || (32'(hdr_n_c) > 32'(IMEM_DEPTH))) begin
            state_d    = S_DONE;
            load_err_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (rx_hs_c) begin
          if (byte_cnt_q == 2'd3) begin
            ins_mem_en_d   = 1'b1;
            ins_mem_data_d = WIDTH'({bus.rxData, asm_q});
            ins_mem_addr_d = WIDTH'(idx_q);
            idx_d          = idx_q + IDX_W'(1);
            byte_cnt_d     = '0;
          end else begin
            asm_d[byte_cnt_q*8 +: 8] = bus.rxData;
            byte_cnt_d               = byte_cnt_q + 2'd1;
          end
        end
        // Leave one cycle after the final word's strobe.
        if (ins_mem_en_q && (idx_q == n_q)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (exit_hit_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (bus.gp == WIDTH'(1)) && (bus.a0 == '0);
        end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d  = ((state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD)) &&
                  !last_byte_c;
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign bus.rxReady    = rx_ready_q;
  assign bus.insMemEn   = ins_mem_en_q;
  assign bus.insMemAddr = ins_mem_addr_q;
  assign bus.insMemData = ins_mem_data_q;
  assign bus.cpuReset   = cpu_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.loadErr    = load_err_q;
  assign bus.cycleCount = cycle_count_q;

endmodule
